// File: rtl/mpx_pkg.sv
// mpx_pkg: shared types, default widths and the signed clamp helper for
// the stereo-MPX composer.
package mpx_pkg;

    localparam int DW_DEF          = 18;
    localparam int SW_DEF          = 8;
    localparam int KPW_DEF         = 4;
    localparam int KFW_DEF         = 8;
    localparam int OW_DEF          = 24;
    localparam int PILOT_SHIFT_DEF = 5;
    localparam int KF_SHIFT_DEF    = 5;

    // Container width for clamp arithmetic; must exceed every value clamped.
    localparam int CW = 48;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_MUL_P = 3'd1,
        ST_MUL_S = 3'd2,
        ST_SUM   = 3'd3,
        ST_MUL_D = 3'd4,
        ST_OUT   = 3'd5
    } state_t;

    // Clamp a signed value to the range of a signed 'width'-bit word.
    function automatic logic signed [CW-1:0] sat_to(input logic signed [CW-1:0] value,
                                                    input int unsigned width);
        logic signed [CW-1:0] hi;
        logic signed [CW-1:0] lo;
        logic signed [CW-1:0] result;
        hi = (48'sd1 <<< (width - 32'd1)) - 48'sd1;
        lo = -hi - 48'sd1;
        if (value > hi) begin
            result = hi;
        end else if (value < lo) begin
            result = lo;
        end else begin
            result = value;
        end
        return result;
    endfunction

endpackage

// File: rtl/mpx_fm_composer_seqmult.sv
// mpx_seqmult: signed x signed shift-add multiplier with a fixed iteration
// count of BW. The start cycle performs iteration 0, so the product is in
// 'product' right after the edge at which 'done' is high. The multiplier bit
// of weight 2^(BW-1) carries negative weight, so a zero-extended unsigned
// operand works as long as its top bit is 0.
module mpx_seqmult
    import mpx_pkg::*;
#(
    parameter int AW = 19,
    parameter int BW = 9
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic signed [AW-1:0]    a,
    input  logic signed [BW-1:0]    b,
    output logic signed [AW+BW-1:0] product,
    output logic                    active,
    output logic                    done
);

    localparam int PW   = AW + BW;
    localparam int CNTW = $clog2(BW) + 1;

    logic signed [PW-1:0] acc_r;
    logic signed [PW-1:0] mcand_r;
    logic [BW-1:0]        mplier_r;
    logic [CNTW-1:0]      cnt_r;
    logic                 active_r;
    logic signed [PW-1:0] term_s;
    logic                 last_s;

    // Partial product for the current bit and detection of the final (negative-weight) bit.
    always_comb begin
        term_s = {PW{1'b0}};
        if (mplier_r[0]) begin
            term_s = mcand_r;
        end else begin
            term_s = {PW{1'b0}};
        end
        last_s = (cnt_r == CNTW'(BW - 1));
    end

    // Load operands on start, then accumulate one multiplier bit per cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            acc_r    <= {PW{1'b0}};
            mcand_r  <= {PW{1'b0}};
            mplier_r <= {BW{1'b0}};
            cnt_r    <= {CNTW{1'b0}};
            active_r <= 1'b0;
        end else if (start) begin
            acc_r    <= b[0] ? PW'(a) : {PW{1'b0}};
            mcand_r  <= PW'(a) <<< 1;
            mplier_r <= {1'b0, b[BW-1:1]};
            cnt_r    <= CNTW'(1);
            active_r <= 1'b1;
        end else if (active_r) begin
            if (last_s) begin
                acc_r    <= acc_r - term_s;
                active_r <= 1'b0;
            end else begin
                acc_r    <= acc_r + term_s;
                active_r <= 1'b1;
            end
            mcand_r  <= mcand_r <<< 1;
            mplier_r <= mplier_r >> 1;
            cnt_r    <= cnt_r + CNTW'(1);
        end else begin
            acc_r    <= acc_r;
            active_r <= 1'b0;
        end
    end

    assign product = acc_r;
    assign active  = active_r;
    assign done    = active_r && last_s;

endmodule

// File: rtl/mpx_fm_composer.sv
// mpx_fm_composer: stereo-MPX composer and FM deviation scaler.
// fm_out = clamp((clamp(left + Kp*pilot + right*sub38) * kf) >>> KF_SHIFT)
// computed over a fixed schedule with one shared sequential multiplier.
// Optional build macro MPX_ROUND_EN: round-half-up on the arithmetic right
// shifts of the subcarrier and deviation products (floor when undefined).
module mpx_fm_composer
    import mpx_pkg::*;
#(
    parameter int DW          = DW_DEF,
    parameter int SW          = SW_DEF,
    parameter int KPW         = KPW_DEF,
    parameter int KFW         = KFW_DEF,
    parameter int OW          = OW_DEF,
    parameter int PILOT_SHIFT = PILOT_SHIFT_DEF,
    parameter int KF_SHIFT    = KF_SHIFT_DEF
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 clken_192,
    input  logic signed [DW-1:0] left,
    input  logic signed [DW-1:0] right,
    input  logic signed [SW-1:0] sine_19,
    input  logic signed [SW-1:0] sine_38,
    input  logic [KPW-1:0]       kp,
    input  logic [KFW-1:0]       kf,
    input  logic                 stereo_en,
    output logic signed [OW-1:0] fm_out,
    output logic                 fm_valid,
    output logic                 busy,
    output logic                 sat,
    output logic                 overrun
);

    // Composite m is held to +/-2^DW; the multiplier A port must fit m,
    // audio and sine samples, and B carries kp, kf or sub38 in KFW+1 bits.
    localparam int MW = DW + 1;
    localparam int AW = DW + 1;
    localparam int BW = KFW + 1;
    localparam int PW = AW + BW;
`ifdef MPX_ROUND_EN
    localparam int SUMW = DW + 4;
    localparam logic signed [PW:0] S_RND = (PW+1)'(1'b1) <<< (SW - 2);
    localparam logic signed [PW:0] D_RND = (PW+1)'(1'b1) <<< (KF_SHIFT - 1);
`else
    localparam int SUMW = DW + 3;
`endif

    state_t state_r;
    state_t state_next_s;

    logic signed [DW-1:0]   left_r;
    logic signed [DW-1:0]   right_r;
    logic signed [SW-1:0]   sine_19_r;
    logic signed [SW-1:0]   sine_38_r;
    logic [KPW-1:0]         kp_r;
    logic [KFW-1:0]         kf_r;
    logic                   stereo_r;
    logic signed [SUMW-1:0] p_r;
    logic signed [MW-1:0]   m_r;
    logic                   sum_sat_r;
    logic signed [OW-1:0]   fm_out_r;
    logic                   fm_valid_r;
    logic                   busy_r;
    logic                   sat_r;
    logic                   overrun_r;

    logic signed [AW-1:0]   mul_a_s;
    logic signed [BW-1:0]   mul_b_s;
    logic signed [PW-1:0]   mul_prod_s;
    logic                   mul_active_s;
    logic                   mul_done_s;
    logic                   mul_start_s;

    logic signed [SUMW-1:0] p_s;
    logic signed [SUMW-1:0] s_s;
    logic signed [SUMW-1:0] s_term_s;
    logic signed [SUMW-1:0] m_full_s;
    logic signed [PW:0]     s_wide_s;
    logic signed [PW:0]     d_wide_s;
    logic signed [PW:0]     d_shift_s;
    logic signed [CW-1:0]   m_clamp_s;
    logic signed [CW-1:0]   d_clamp_s;
    logic                   m_sat_s;
    logic                   d_sat_s;

    mpx_seqmult #(
        .AW (AW),
        .BW (BW)
    ) u_mult (
        .clock   (clock),
        .reset   (reset),
        .start   (mul_start_s),
        .a       (mul_a_s),
        .b       (mul_b_s),
        .product (mul_prod_s),
        .active  (mul_active_s),
        .done    (mul_done_s)
    );

    // FSM state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic: each MUL state ends when the multiplier reports done.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (clken_192) begin
                    state_next_s = ST_MUL_P;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_MUL_P: begin
                if (mul_done_s) begin
                    state_next_s = ST_MUL_S;
                end else begin
                    state_next_s = ST_MUL_P;
                end
            end
            ST_MUL_S: begin
                if (mul_done_s) begin
                    state_next_s = ST_SUM;
                end else begin
                    state_next_s = ST_MUL_S;
                end
            end
            ST_SUM:   state_next_s = ST_MUL_D;
            ST_MUL_D: begin
                if (mul_done_s) begin
                    state_next_s = ST_OUT;
                end else begin
                    state_next_s = ST_MUL_D;
                end
            end
            ST_OUT:   state_next_s = ST_IDLE;
            default:  state_next_s = ST_IDLE;
        endcase
    end

    // Multiplier operand selection; a MUL state starts the multiplier on its first cycle.
    always_comb begin
        mul_a_s     = {AW{1'b0}};
        mul_b_s     = {BW{1'b0}};
        mul_start_s = 1'b0;
        case (state_r)
            ST_MUL_P: begin
                mul_a_s = AW'(sine_19_r);
                mul_b_s = $signed(BW'(kp_r));
            end
            ST_MUL_S: begin
                mul_a_s = AW'(right_r);
                mul_b_s = BW'(sine_38_r);
            end
            ST_MUL_D: begin
                mul_a_s = AW'(m_r);
                mul_b_s = $signed({1'b0, kf_r});
            end
            default: begin
                mul_a_s = {AW{1'b0}};
                mul_b_s = {BW{1'b0}};
            end
        endcase
        if ((state_r == ST_MUL_P || state_r == ST_MUL_S || state_r == ST_MUL_D) && !mul_active_s) begin
            mul_start_s = 1'b1;
        end else begin
            mul_start_s = 1'b0;
        end
    end

    // Scaling of the multiplier product for the pilot, subcarrier and deviation terms.
    always_comb begin
`ifdef MPX_ROUND_EN
        s_wide_s = (PW+1)'(mul_prod_s) + S_RND;
        d_wide_s = (PW+1)'(mul_prod_s) + D_RND;
`else
        s_wide_s = (PW+1)'(mul_prod_s);
        d_wide_s = (PW+1)'(mul_prod_s);
`endif
        p_s       = SUMW'(mul_prod_s) <<< PILOT_SHIFT;
        s_s       = SUMW'(s_wide_s >>> (SW - 1));
        d_shift_s = d_wide_s >>> KF_SHIFT;
        if (stereo_r) begin
            s_term_s = s_s;
        end else begin
            s_term_s = {SUMW{1'b0}};
        end
        m_full_s  = SUMW'(left_r) + p_r + s_term_s;
        m_clamp_s = sat_to(CW'(m_full_s), MW);
        m_sat_s   = (m_clamp_s != CW'(m_full_s));
        d_clamp_s = sat_to(CW'(d_shift_s), OW);
        d_sat_s   = (d_clamp_s != CW'(d_shift_s));
    end

    // Capture, intermediate results, output word and status flags.
    always_ff @(posedge clock) begin
        if (reset) begin
            left_r     <= {DW{1'b0}};
            right_r    <= {DW{1'b0}};
            sine_19_r  <= {SW{1'b0}};
            sine_38_r  <= {SW{1'b0}};
            kp_r       <= {KPW{1'b0}};
            kf_r       <= {KFW{1'b0}};
            stereo_r   <= 1'b0;
            p_r        <= {SUMW{1'b0}};
            m_r        <= {MW{1'b0}};
            sum_sat_r  <= 1'b0;
            fm_out_r   <= {OW{1'b0}};
            fm_valid_r <= 1'b0;
            busy_r     <= 1'b0;
            sat_r      <= 1'b0;
            overrun_r  <= 1'b0;
        end else begin
            fm_valid_r <= 1'b0;
            busy_r     <= (state_next_s != ST_IDLE);
            if (clken_192 && state_r != ST_IDLE) begin
                overrun_r <= 1'b1;
            end
            case (state_r)
                ST_IDLE: begin
                    if (clken_192) begin
                        left_r    <= left;
                        right_r   <= right;
                        sine_19_r <= sine_19;
                        sine_38_r <= sine_38;
                        kp_r      <= kp;
                        kf_r      <= kf;
                        stereo_r  <= stereo_en;
                    end
                end
                ST_MUL_S: begin
                    // The pilot product is still in the multiplier on this state's first cycle.
                    if (mul_start_s) begin
                        p_r <= stereo_r ? p_s : {SUMW{1'b0}};
                    end
                end
                ST_SUM: begin
                    m_r       <= MW'(m_clamp_s);
                    sum_sat_r <= m_sat_s;
                end
                ST_OUT: begin
                    fm_out_r   <= OW'(d_clamp_s);
                    fm_valid_r <= 1'b1;
                    sat_r      <= sum_sat_r | d_sat_s;
                end
                default: begin
                    fm_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign fm_out   = fm_out_r;
    assign fm_valid = fm_valid_r;
    assign busy     = busy_r;
    assign sat      = sat_r;
    assign overrun  = overrun_r;

endmodule

// File: tb/tb_mpx_fm_composer.sv
// tb_mpx_fm_composer: directed checks of mpx_fm_composer at default parameters.
module tb_mpx_fm_composer;

    logic               clock = 1'b0;
    logic               reset;
    logic               clken_192;
    logic signed [17:0] left;
    logic signed [17:0] right;
    logic signed [7:0]  sine_19;
    logic signed [7:0]  sine_38;
    logic [3:0]         kp;
    logic [7:0]         kf;
    logic               stereo_en;
    logic signed [23:0] fm_out;
    logic               fm_valid;
    logic               busy;
    logic               sat;
    logic               overrun;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc;
    int pulses;

    always #5 clock = ~clock;

    mpx_fm_composer dut (
        .clock     (clock),
        .reset     (reset),
        .clken_192 (clken_192),
        .left      (left),
        .right     (right),
        .sine_19   (sine_19),
        .sine_38   (sine_38),
        .kp        (kp),
        .kf        (kf),
        .stereo_en (stereo_en),
        .fm_out    (fm_out),
        .fm_valid  (fm_valid),
        .busy      (busy),
        .sat       (sat),
        .overrun   (overrun)
    );

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic st, input int l, input int r, input int s19,
                          input int s38, input int k_p, input int k_f);
        stereo_en = st;
        left      = 18'(l);
        right     = 18'(r);
        sine_19   = 8'(s19);
        sine_38   = 8'(s38);
        kp        = 4'(k_p);
        kf        = 8'(k_f);
    endtask

    // One-cycle clken pulse; returns 1 time unit after the capture edge.
    task automatic capture();
        clken_192 = 1'b1;
        @(posedge clock);
        #1;
        clken_192 = 1'b0;
    endtask

    // Cycles from the clken cycle up to and including the cycle fm_valid is seen; -1 on timeout.
    task automatic wait_valid(output int cycles);
        cycles = 1;
        for (int i = 0; i < 60; i++) begin
            @(posedge clock);
            #1;
            cycles++;
            if (fm_valid) begin
                return;
            end
        end
        cycles = -1;
    endtask

    task automatic watch(input int ncyc, output int count);
        count = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(posedge clock);
            #1;
            if (fm_valid) begin
                count++;
            end
        end
    endtask

    initial begin
        reset     = 1'b1;
        clken_192 = 1'b0;
        set_in(1'b0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        chk("reset_fm_out", fm_out, 64'sd0);
        chk("reset_fm_valid", fm_valid, 64'sd0);
        chk("reset_busy", busy, 64'sd0);
        chk("reset_sat", sat, 64'sd0);
        chk("reset_overrun", overrun, 64'sd0);

        // Mono passthrough, positive.
        set_in(1'b0, 1000, 5000, 100, 100, 15, 32);
        capture();
        chk("mono_busy_rise", busy, 64'sd1);
        wait_valid(cyc);
        chk("mono_latency", cyc, 64'sd30);
        chk("mono_fm_out", fm_out, 64'sd1000);
        chk("mono_sat", sat, 64'sd0);
        chk("mono_busy_fall", busy, 64'sd0);
        @(posedge clock);
        #1;
        chk("mono_valid_single", fm_valid, 64'sd0);

        // Mono passthrough, negative.
        set_in(1'b0, -1000, 0, 0, 0, 0, 32);
        capture();
        wait_valid(cyc);
        chk("mono_neg_latency", cyc, 64'sd30);
        chk("mono_neg_fm_out", fm_out, -64'sd1000);

        // Composite saturation: m clamps to 262143, fm_out = 262143*255>>5.
        set_in(1'b1, 131071, 131071, 127, 127, 15, 255);
        capture();
        wait_valid(cyc);
        chk("sat_latency", cyc, 64'sd30);
        chk("sat_fm_out", fm_out, 64'sd2088952);
        chk("sat_flag", sat, 64'sd1);

        // Subcarrier shift: 1*64 >>> 7 rounds to 1 or floors to 0.
        set_in(1'b1, 0, 1, 0, 64, 0, 32);
        capture();
        wait_valid(cyc);
`ifdef MPX_ROUND_EN
        chk("round_fm_out", fm_out, 64'sd1);
`else
        chk("round_fm_out", fm_out, 64'sd0);
`endif
        chk("round_sat", sat, 64'sd0);

        // Stereo, no clamp: p = 10*3<<5 = 960, s = -2000*-64>>>7 = 1000, m = 2460, d = 2460*64>>5.
        set_in(1'b1, 500, -2000, 10, -64, 3, 64);
        capture();
        wait_valid(cyc);
        chk("stereo_fm_out", fm_out, 64'sd4920);
        chk("stereo_sat", sat, 64'sd0);

        // Inputs changed after capture do not affect the result.
        set_in(1'b0, 500, 0, 0, 0, 0, 32);
        capture();
        left = 18'sd7777;
        kf   = 8'd255;
        wait_valid(cyc);
        chk("hold_fm_out", fm_out, 64'sd500);
        chk("hold_overrun_clear", overrun, 64'sd0);

        // Second pulse 20 cycles after the first is ignored.
        set_in(1'b0, 300, 0, 0, 0, 0, 32);
        capture();
        repeat (19) @(posedge clock);
        #1;
        left = 18'sd999;
        clken_192 = 1'b1;
        @(posedge clock);
        #1;
        clken_192 = 1'b0;
        chk("ovr20_overrun", overrun, 64'sd1);
        watch(40, pulses);
        chk("ovr20_pulses", pulses, 64'sd1);
        chk("ovr20_fm_out", fm_out, 64'sd300);
        chk("ovr20_sticky", overrun, 64'sd1);

        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        chk("rst_clears_overrun", overrun, 64'sd0);

        // Pulse on the OUT edge is also an overrun.
        set_in(1'b0, 200, 0, 0, 0, 0, 32);
        capture();
        repeat (28) @(posedge clock);
        #1;
        clken_192 = 1'b1;
        @(posedge clock);
        #1;
        clken_192 = 1'b0;
        chk("ovrout_valid", fm_valid, 64'sd1);
        chk("ovrout_fm_out", fm_out, 64'sd200);
        chk("ovrout_overrun", overrun, 64'sd1);
        watch(40, pulses);
        chk("ovrout_no_extra", pulses, 64'sd0);

        // Reset mid-operation abandons the computation.
        set_in(1'b1, 131071, 131071, 127, 127, 15, 255);
        capture();
        repeat (14) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        chk("midrst_fm_out", fm_out, 64'sd0);
        chk("midrst_busy", busy, 64'sd0);
        chk("midrst_sat", sat, 64'sd0);
        chk("midrst_overrun", overrun, 64'sd0);
        watch(40, pulses);
        chk("midrst_no_valid", pulses, 64'sd0);

        set_in(1'b0, 1000, 0, 0, 0, 0, 32);
        capture();
        wait_valid(cyc);
        chk("post_rst_latency", cyc, 64'sd30);
        chk("post_rst_fm_out", fm_out, 64'sd1000);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
